// File: rtl/fix_output_round_sat.sv
// Output stage of the float-to-fixed linearizer: round-to-nearest-even on the guard
// bits, then sign and saturate, through a two-stage valid/ready pipeline with a saturation counter.
module fix_output_round_sat #(
  parameter int unsigned SWR = 26,
  parameter int unsigned GRD = 2,
  parameter int unsigned W   = 32,
  parameter int unsigned CW  = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           valid_i,
  output logic           ready_o,
  input  logic [SWR-1:0] Data_i,
  input  logic           sign_i,
  input  logic           ovf_i,
  output logic           valid_o,
  input  logic           ready_i,
  output logic [W-1:0]   Data_o,
  output logic           sat_o,
  output logic [CW-1:0]  sat_count_o,
  input  logic           clr_count_i
);

  // One extra bit so the rounding carry out of the top magnitude bit is kept.
  localparam int unsigned MW = W + 1;
  localparam logic [MW-1:0] POS_LIM   = {2'b00, {(W-1){1'b1}}};
  localparam logic [MW-1:0] NEG_LIM   = {2'b01, {(W-1){1'b0}}};
  localparam logic [W-1:0]  POS_SAT   = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]  NEG_SAT   = {1'b1, {(W-1){1'b0}}};
  localparam logic [CW-1:0] CNT_MAX   = '1;

  logic          s1_valid;
  logic [MW-1:0] s1_mag;
  logic          s1_sign;
  logic          s1_ovf;

  logic          s1_load;
  logic          s2_adv;
  logic          out_xfer;

  logic [MW-1:0] mag_c;
  logic          rnd_c;
  logic          sticky_c;
  logic          inc_c;
  logic [MW-1:0] rounded_c;

  logic          sat_c;
  logic [W-1:0]  low_c;
  logic [W-1:0]  word_c;

  // Handshake: stage 1 frees up in the same cycle it hands its word on.
  always_comb begin
    s2_adv   = s1_valid & (~valid_o | ready_i);
    ready_o  = ~s1_valid | s2_adv;
    s1_load  = valid_i & ready_o;
    out_xfer = valid_o & ready_i;
  end

  // Round-to-nearest-even of the incoming magnitude.
  always_comb begin
    mag_c     = MW'(Data_i[SWR-1:GRD]);
    rnd_c     = Data_i[GRD-1];
    sticky_c  = |Data_i[GRD-2:0];
    inc_c     = rnd_c & (sticky_c | mag_c[0]);
    rounded_c = mag_c + MW'(inc_c);
  end

  // Sign and saturate; the negative range reaches one step further than the positive one.
  always_comb begin
    sat_c  = s1_ovf
           | (~s1_sign & (s1_mag > POS_LIM))
           | ( s1_sign & (s1_mag > NEG_LIM));
    low_c  = s1_mag[W-1:0];
    word_c = s1_sign ? (~low_c + W'(1)) : low_c;
    if (sat_c) begin
      word_c = s1_sign ? NEG_SAT : POS_SAT;
    end
  end

  // Stage 1: rounded magnitude plus sign and overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_mag   <= '0;
      s1_sign  <= 1'b0;
      s1_ovf   <= 1'b0;
    end else begin
      if (s1_load) begin
        s1_valid <= 1'b1;
        s1_mag   <= rounded_c;
        s1_sign  <= sign_i;
        s1_ovf   <= ovf_i;
      end else if (s2_adv) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // Stage 2: output word, held while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_o <= 1'b0;
      Data_o  <= '0;
      sat_o   <= 1'b0;
    end else begin
      if (s2_adv) begin
        valid_o <= 1'b1;
        Data_o  <= word_c;
        sat_o   <= sat_c;
      end else if (out_xfer) begin
        valid_o <= 1'b0;
      end
    end
  end

  // Saturated-word counter: sticks at its maximum, clear has priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_count_o <= '0;
    end else if (clr_count_i) begin
      sat_count_o <= '0;
    end else if (out_xfer && sat_o && (sat_count_o != CNT_MAX)) begin
      sat_count_o <= sat_count_o + CW'(1);
    end
  end

endmodule

// File: tb/tb_fix_output_round_sat.sv
// Bench for fix_output_round_sat: directed and random traffic compared against an
// arithmetic rounding model and a word queue that tracks what is in flight.
module tb_fix_output_round_sat;

  localparam int unsigned SWR = 33;
  localparam int unsigned GRD = 2;
  localparam int unsigned W   = 32;
  localparam int unsigned CW  = 2;
  localparam int          CMAX = (1 << CW) - 1;

  logic           clk = 1'b0;
  logic           rst;
  logic           valid_i;
  logic           ready_o;
  logic [SWR-1:0] Data_i;
  logic           sign_i;
  logic           ovf_i;
  logic           valid_o;
  logic           ready_i;
  logic [W-1:0]   Data_o;
  logic           sat_o;
  logic [CW-1:0]  sat_count_o;
  logic           clr_count_i;

  fix_output_round_sat #(.SWR(SWR), .GRD(GRD), .W(W), .CW(CW)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o), .Data_i(Data_i),
    .sign_i(sign_i), .ovf_i(ovf_i), .valid_o(valid_o), .ready_i(ready_i),
    .Data_o(Data_o), .sat_o(sat_o), .sat_count_o(sat_count_o), .clr_count_i(clr_count_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    logic         sat;
    int           acc;
  } word_t;

  word_t q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    exp_cnt = 0;
  bit    last_in_x;
  bit    saw_stall;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: integer divide by 2^GRD, ties to even, then clamp to the signed W-bit range.
  function automatic word_t model(input logic [SWR-1:0] d, input logic s, input logic o);
    word_t  r;
    longint dv   = longint'(d);
    longint div  = longint'(1) << GRD;
    longint half = div / 2;
    longint qt   = dv / div;
    longint rem  = dv % div;
    longint v;
    longint pmax = (longint'(1) << (W - 1)) - 1;
    longint nmin = -(longint'(1) << (W - 1));
    if (rem > half || (rem == half && (qt % 2) == 1)) qt = qt + 1;
    v = s ? -qt : qt;
    r.sat  = o || (v > pmax) || (v < nmin);
    r.data = r.sat ? (s ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}}) : W'(v);
    r.acc  = 0;
    return r;
  endfunction

  function automatic bit vexp();
    return (q.size() > 0) && (q[0].acc < cyc);
  endfunction

  // One clock: check outputs mid-cycle, update the model for the coming edge, check the counter after it.
  task automatic tick();
    bit    in_x, out_x, rdy_exp;
    word_t w;
    @(negedge clk);
    rdy_exp = (q.size() < 2) || ready_i;
    chk("ready_o", 64'(ready_o), 64'(rdy_exp));
    chk("valid_o", 64'(valid_o), 64'(vexp()));
    if (vexp()) begin
      chk("Data_o", 64'(Data_o), 64'(q[0].data));
      chk("sat_o", 64'(sat_o), 64'(q[0].sat));
    end
    if (!ready_o && q.size() == 2) saw_stall = 1'b1;
    in_x  = valid_i && rdy_exp;
    out_x = vexp() && ready_i;
    if (clr_count_i) exp_cnt = 0;
    else if (out_x && q[0].sat && exp_cnt < CMAX) exp_cnt++;
    if (out_x) void'(q.pop_front());
    if (in_x) begin
      w = model(Data_i, sign_i, ovf_i);
      w.acc = cyc + 1;
      q.push_back(w);
    end
    last_in_x = in_x;
    @(posedge clk);
    #1;
    cyc++;
    chk("sat_count_o", 64'(sat_count_o), 64'(exp_cnt));
  endtask

  task automatic send(input logic [SWR-1:0] d, input logic s, input logic o);
    valid_i = 1'b1; Data_i = d; sign_i = s; ovf_i = o;
    tick();
    valid_i = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    valid_i = 1'b0;
    ready_i = 1'b1;
    while (q.size() > 0 && guard < 50) begin
      tick();
      guard++;
    end
    chk("drain_empty", 64'(q.size()), 64'(0));
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
    rst = 1'b0;
    q.delete();
    exp_cnt = 0;
    chk("rst_valid_o", 64'(valid_o), 64'(0));
    chk("rst_Data_o", 64'(Data_o), 64'(0));
    chk("rst_sat_o", 64'(sat_o), 64'(0));
    chk("rst_ready_o", 64'(ready_o), 64'(1));
    chk("rst_count", 64'(sat_count_o), 64'(0));
  endtask

  initial begin
    logic [SWR-1:0] words [6];
    int idx;

    rst = 1'b0; valid_i = 1'b0; Data_i = '0; sign_i = 1'b0; ovf_i = 1'b0;
    ready_i = 1'b1; clr_count_i = 1'b0;
    @(posedge clk); #1;
    do_reset();

    // Rounding cases on a back-to-back stream
    valid_i = 1'b1; sign_i = 1'b0;
    Data_i = SWR'(5); tick();
    Data_i = SWR'(6); tick();
    Data_i = SWR'(2); tick();
    Data_i = SWR'(7); tick();
    valid_i = 1'b0;
    drain();

    // Negative values, including negative zero
    send(SWR'(7), 1'b1, 1'b0);
    send(SWR'(1), 1'b1, 1'b0);
    drain();

    // Forced saturation and the magnitude limits of both signs
    send(SWR'(3), 1'b0, 1'b1);
    send(SWR'(3), 1'b1, 1'b1);
    drain();
    chk("ovf_count", 64'(sat_count_o), 64'(2));
    send({31'h7FFF_FFFF, 2'b01}, 1'b0, 1'b0);
    send({31'h7FFF_FFFF, 2'b10}, 1'b0, 1'b0);
    send({31'h7FFF_FFFF, 2'b10}, 1'b1, 1'b0);
    send({31'h7FFF_FFFF, 2'b11}, 1'b1, 1'b0);
    drain();

    // Six-word stream with a four-cycle consumer stall
    clr_count_i = 1'b1; tick(); clr_count_i = 1'b0;
    for (int i = 0; i < 6; i++) words[i] = SWR'({$urandom(), $urandom()});
    idx = 0;
    saw_stall = 1'b0;
    for (int k = 0; k < 40 && (idx < 6 || q.size() > 0); k++) begin
      ready_i = !(k >= 3 && k < 7);
      valid_i = (idx < 6);
      Data_i  = words[idx < 6 ? idx : 5];
      sign_i  = idx[0];
      ovf_i   = 1'b0;
      tick();
      if (last_in_x) idx++;
    end
    valid_i = 1'b0;
    chk("stall_all_sent", 64'(idx), 64'(6));
    chk("stall_seen", 64'(saw_stall), 64'(1));
    drain();

    // Counter sticks at its maximum, then clear beats a simultaneous increment
    for (int i = 0; i < 5; i++) send(SWR'($urandom()), 1'($urandom()), 1'b1);
    drain();
    chk("count_max", 64'(sat_count_o), 64'(CMAX));
    valid_i = 1'b1; Data_i = '0; sign_i = 1'b0; ovf_i = 1'b1;
    tick();
    valid_i = 1'b0;
    for (int k = 0; k < 5 && !vexp(); k++) tick();
    clr_count_i = 1'b1;
    tick();
    clr_count_i = 1'b0;
    chk("clr_wins", 64'(sat_count_o), 64'(0));
    drain();

    // Reset with both stages full and the consumer stalled
    send(SWR'(100), 1'b0, 1'b1);
    ready_i = 1'b0;
    send(SWR'(200), 1'b0, 1'b0);
    send(SWR'(300), 1'b0, 1'b0);
    chk("full_before_rst", 64'(q.size()), 64'(2));
    do_reset();
    ready_i = 1'b1;
    send(SWR'(41), 1'b1, 1'b0);
    tick();
    tick();
    drain();

    // Random traffic with random stalls, don't-care inputs and counter clears
    for (int k = 0; k < 400; k++) begin
      valid_i     = ($urandom_range(0, 3) != 0);
      ready_i     = ($urandom_range(0, 3) != 0);
      Data_i      = ($urandom_range(0, 1) != 0) ? SWR'({$urandom(), $urandom()}) : SWR'($urandom_range(0, 31));
      sign_i      = 1'($urandom());
      ovf_i       = ($urandom_range(0, 7) == 0);
      clr_count_i = ($urandom_range(0, 31) == 0);
      tick();
    end
    clr_count_i = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
